// File: rtl/dmem_mmio_responder_pkg.sv
// rtl/dmem_mmio_responder_pkg.sv - shared register map constants for the data-side MMIO responder
// Package mmio_pkg:
//   reg_idx_e  : MMIO register index decoded from memaddr[3:2]
//   ST_*       : bit positions inside the STATUS register
//   CMP_RESET  : compare register value after reset
package mmio_pkg;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_TIMER  = 2'd2,
    REG_CMP    = 2'd3
  } reg_idx_e;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF   = 2;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/dmem_mmio_responder_sync_fifo.sv
// rtl/dmem_mmio_responder_sync_fifo.sv - synchronous FIFO with full/empty/count and drop-on-full
// Module sync_fifo:
//   clk, reset    : clock, synchronous active-high reset
//   push_i/wdata_i: enqueue request and data (ignored when full unless popping)
//   pop_i         : dequeue request (ignored when empty)
//   rdata_o       : head entry, 0 when empty
//   full_o/empty_o/count_o : occupancy flags and entry count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// rtl/dmem_mmio_responder.sv - MEM-stage data responder: word RAM, TX FIFO MMIO, optional compare timer
// Optional feature macro: MMIO_TIMER_EN (TIMER/CMP registers and timer_irq; otherwise they read 0).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   memwrite      : write strobe, commits on rising clk
//   memaddr       : byte address (bits [1:0] ignored)
//   memwritedata  : write data
//   memreaddata   : combinational read data, 0 while reset is high
//   tx_data/tx_valid/tx_ready : FIFO drain handshake toward the debug console
//   timer_irq     : sticky timer/compare match flag
module dmem_mmio_responder
  import mmio_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [32:0] RAM_LIMIT = 33'(RAM_WORDS) * 33'd4;

  logic           is_mmio, is_ram;
  reg_idx_e       reg_idx;
  logic [RAW-1:0] ram_idx;
  logic           wr_mmio, wr_txdata, wr_status;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [FAW:0]   fifo_count;
  logic [7:0]     fifo_rdata;
  logic           ovf_q, ovf_d;
  logic [31:0]    status_w, timer_rd, cmp_rd;
  logic [31:0]    ram_q [RAM_WORDS];

  // MMIO window takes priority over the RAM range.
  assign is_mmio   = (memaddr[31:16] == MMIO_BASE[31:16]);
  assign is_ram    = !is_mmio && ({1'b0, memaddr} < RAM_LIMIT);
  assign reg_idx   = reg_idx_e'(memaddr[3:2]);
  assign ram_idx   = memaddr[RAW+1:2];

  assign wr_mmio   = memwrite & is_mmio & ~reset;
  assign wr_txdata = wr_mmio & (reg_idx == REG_TXDATA);
  assign wr_status = wr_mmio & (reg_idx == REG_STATUS);

  // RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (memwrite && is_ram) ram_q[ram_idx] <= memwritedata;
  end

  // Reset blocks the handshake so no byte is consumed in a reset cycle.
  assign fifo_pop = tx_valid & tx_ready & ~reset;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_txdata),
    .wdata_i (memwritedata[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tx_valid = ~fifo_empty;
  assign tx_data  = fifo_rdata;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_status && memwritedata[ST_OVF]) ovf_d = 1'b0;
    else if (wr_txdata && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  always_comb begin
    status_w           = '0;
    status_w[ST_FULL]  = fifo_full;
    status_w[ST_EMPTY] = fifo_empty;
    status_w[ST_OVF]   = ovf_q;
  end

`ifdef MMIO_TIMER_EN
  logic        wr_timer, wr_cmp;
  logic [31:0] timer_q, timer_d, cmp_q, cmp_d;
  logic        irq_q, irq_d;

  assign wr_timer = wr_mmio & (reg_idx == REG_TIMER);
  assign wr_cmp   = wr_mmio & (reg_idx == REG_CMP);

  // A CMP write clears the flag even when it coincides with a match.
  always_comb begin
    timer_d = wr_timer ? memwritedata : timer_q + 32'd1;
    cmp_d   = wr_cmp ? memwritedata : cmp_q;
    irq_d   = irq_q;
    if (wr_cmp) irq_d = 1'b0;
    else if (timer_q == cmp_q) irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
      cmp_q   <= CMP_RESET;
      irq_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
    end
  end

  assign timer_rd  = timer_q;
  assign cmp_rd    = cmp_q;
  assign timer_irq = irq_q;
`else
  assign timer_rd  = '0;
  assign cmp_rd    = '0;
  assign timer_irq = 1'b0;
`endif

  // Reads see the state before the current edge, so read-during-write returns the old value.
  always_comb begin
    memreaddata = '0;
    if (!reset) begin
      if (is_mmio) begin
        case (reg_idx)
          REG_TXDATA: memreaddata = {24'b0, 8'(fifo_count)};
          REG_STATUS: memreaddata = status_w;
          REG_TIMER:  memreaddata = timer_rd;
          REG_CMP:    memreaddata = cmp_rd;
          default:    memreaddata = '0;
        endcase
      end else if (is_ram) begin
        memreaddata = ram_q[ram_idx];
      end
    end
  end

endmodule
